// File: rtl/dbus_access_unit_pkg.sv
// Shared types for the data-bus access unit: access sizes, bus payloads,
// FSM state encoding and the size-decode helpers used by the core.
package dbus_access_unit_pkg;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned OW = 3;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef logic [SW-1:0] strobe_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        msize_t        size;
        strobe_t       strobe;
        logic [DW-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic          addr_ok;
        logic          data_ok;
        logic [DW-1:0] data;
    } dbus_resp_t;

    typedef logic [1:0] dau_state_t;
    localparam dau_state_t ST_IDLE = 2'd0;
    localparam dau_state_t ST_REQ  = 2'd1;
    localparam dau_state_t ST_WAIT = 2'd2;
    localparam dau_state_t ST_DONE = 2'd3;

    // Unshifted byte enables for an access size; unknown sizes behave as dword.
    function automatic strobe_t size_strobe(input logic [2:0] size);
        case (size)
            MSIZE1:  return strobe_t'(8'h01);
            MSIZE2:  return strobe_t'(8'h03);
            MSIZE4:  return strobe_t'(8'h0f);
            default: return strobe_t'(8'hff);
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] size, input logic [OW-1:0] off);
        case (size)
            MSIZE1:  return 1'b0;
            MSIZE2:  return off[0];
            MSIZE4:  return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/dbus_access_unit_load_extend.sv
// Right-aligns raw bus read data by byte offset and sign/zero-extends
// it to the full data width according to the access size.
module dbus_access_unit_load_extend
    import dbus_access_unit_pkg::*;
(
    input  logic [DW-1:0] i_raw,
    input  logic [OW-1:0] i_off,
    input  logic [2:0]    i_size,
    input  logic          i_unsigned,
    output logic [DW-1:0] o_data_c
);

    logic [DW-1:0] w_shifted;
    logic          w_sext;

    always_comb begin
        w_shifted = i_raw >> {i_off, 3'b000};
        w_sext    = 1'b0;
        o_data_c  = w_shifted;
        case (i_size)
            MSIZE1: begin
                w_sext   = ~i_unsigned & w_shifted[7];
                o_data_c = {{56{w_sext}}, w_shifted[7:0]};
            end
            MSIZE2: begin
                w_sext   = ~i_unsigned & w_shifted[15];
                o_data_c = {{48{w_sext}}, w_shifted[15:0]};
            end
            MSIZE4: begin
                w_sext   = ~i_unsigned & w_shifted[31];
                o_data_c = {{32{w_sext}}, w_shifted[31:0]};
            end
            default: o_data_c = w_shifted;
        endcase
    end

endmodule

// File: rtl/dbus_access_unit.sv
// Memory-stage data-bus access unit: latches one load/store, runs the
// valid/addr_ok/data_ok handshake, stalls the pipe and returns extended load data.
module dbus_access_unit
    import dbus_access_unit_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [2:0]    req_size,
    input  logic          req_unsigned,
    input  logic [DW-1:0] req_wdata,
    output logic          stall,
    output logic          resp_valid,
    output logic [DW-1:0] resp_data,
    output logic          resp_misalign,
    output logic          dreq_valid,
    output logic [AW-1:0] dreq_addr,
    output logic [2:0]    dreq_size,
    output logic [SW-1:0] dreq_strobe,
    output logic [DW-1:0] dreq_data,
    input  logic          dresp_addr_ok,
    input  logic          dresp_data_ok,
    input  logic [DW-1:0] dresp_data
);

    dau_state_t    r_state;
    dau_state_t    w_state_nxt;
    logic          r_write;
    logic          r_unsigned;
    logic [AW-1:0] r_addr;
    logic [2:0]    r_size;
    strobe_t       r_strobe;
    logic [DW-1:0] r_wdata;
    logic          r_misalign;
    logic [DW-1:0] r_resp_data;

    logic          w_accept;
    logic          w_misalign;
    logic          w_data_done;
    logic [DW-1:0] w_ext;
    dbus_req_t     w_dreq;
    dbus_resp_t    w_dresp;

    always_comb begin
        w_dresp.addr_ok = dresp_addr_ok;
        w_dresp.data_ok = dresp_data_ok;
        w_dresp.data    = dresp_data;
    end

    assign w_accept    = (r_state == ST_IDLE) && req_valid;
    assign w_misalign  = is_misaligned(req_size, req_addr[OW-1:0]);
    assign w_data_done = ((r_state == ST_REQ) && w_dresp.addr_ok && w_dresp.data_ok)
                      || ((r_state == ST_WAIT) && w_dresp.data_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_state_nxt = w_misalign ? ST_DONE : ST_REQ;
            ST_REQ: begin
                if (w_dresp.addr_ok) w_state_nxt = w_dresp.data_ok ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: if (w_dresp.data_ok) w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request fields freeze at acceptance so the bus sees stable values until addr_ok.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write     <= 1'b0;
            r_unsigned  <= 1'b0;
            r_addr      <= '0;
            r_size      <= '0;
            r_strobe    <= '0;
            r_wdata     <= '0;
            r_misalign  <= 1'b0;
            r_resp_data <= '0;
        end else if (w_accept) begin
            r_write     <= req_write;
            r_unsigned  <= req_unsigned;
            r_addr      <= req_addr;
            r_size      <= req_size;
            r_strobe    <= req_write ? strobe_t'(size_strobe(req_size) << req_addr[OW-1:0]) : '0;
            r_wdata     <= req_wdata << {req_addr[OW-1:0], 3'b000};
            r_misalign  <= w_misalign;
            r_resp_data <= '0;
        end else if (w_data_done) begin
            r_resp_data <= r_write ? '0 : w_ext;
        end
    end

    dbus_access_unit_load_extend u_load_extend (
        .i_raw      (w_dresp.data),
        .i_off      (r_addr[OW-1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data_c   (w_ext)
    );

    always_comb begin
        w_dreq.valid  = (r_state == ST_REQ);
        w_dreq.addr   = r_addr;
        w_dreq.size   = msize_t'(r_size);
        w_dreq.strobe = r_strobe;
        w_dreq.data   = r_wdata;
    end

    assign dreq_valid    = w_dreq.valid;
    assign dreq_addr     = w_dreq.addr;
    assign dreq_size     = w_dreq.size;
    assign dreq_strobe   = w_dreq.strobe;
    assign dreq_data     = w_dreq.data;
    assign stall         = w_accept || (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign resp_valid    = (r_state == ST_DONE);
    assign resp_misalign = (r_state == ST_DONE) && r_misalign;
    assign resp_data     = r_resp_data;

    // data_ok without addr_ok is a bus protocol violation; the FSM ignores it.
    a_no_data_before_addr: assert property (@(posedge clk) disable iff (!reset)
        ((r_state == ST_REQ) && dresp_data_ok) |-> dresp_addr_ok);

endmodule

// File: tb/tb_dbus_access_unit.sv
// Randomized and directed bench for dbus_access_unit against a
// byte-arithmetic reference model of the load/store transaction rules.
module tb_dbus_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_unsigned;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        stall, resp_valid, resp_misalign, dreq_valid;
    logic [63:0] resp_data, dreq_addr, dreq_data;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dbus_access_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_misalign(resp_misalign), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
    );

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic int nbytes(input logic [2:0] size);
        return 1 << size;
    endfunction

    function automatic logic m_misaligned(input logic [63:0] addr, input logic [2:0] size);
        return (addr % 64'(nbytes(size))) != 0;
    endfunction

    function automatic logic [7:0] m_strobe(input logic [63:0] addr, input logic [2:0] size);
        int full;
        full = ((1 << nbytes(size)) - 1) << int'(addr % 8);
        return 8'(full);
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] raw, input logic [63:0] addr,
                                           input logic [2:0] size, input logic uns);
        int nb;
        logic [63:0] mask, v;
        nb   = nbytes(size);
        mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        v    = (raw >> (8 * int'(addr % 8))) & mask;
        if (!uns && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic idle_inputs();
        req_valid = 0; req_write = 0; req_addr = '0; req_size = '0;
        req_unsigned = 0; req_wdata = '0;
        dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = '0;
    endtask

    // Drives one op from IDLE (cycle 0) and records what the DUT did; no checking here.
    task automatic run_op(input logic wr, input logic [63:0] addr, input logic [2:0] size,
                          input logic uns, input logic [63:0] wdata, input logic [63:0] raw,
                          input int aok, input int dok,
                          output int lat, output logic [63:0] rdata, output logic mis,
                          output int dcnt, output logic [7:0] strb, output logic [63:0] daddr,
                          output logic [63:0] ddata, output logic stable, output logic stall_ok);
        lat = -1; rdata = 'x; mis = 'x; dcnt = 0; strb = '0; daddr = '0; ddata = '0;
        stable = 1; stall_ok = 1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            req_valid = (c == 0); req_write = wr; req_addr = addr; req_size = size;
            req_unsigned = uns; req_wdata = wdata;
            dresp_addr_ok = (c == 1 + aok);
            dresp_data_ok = (c == 1 + aok + dok);
            dresp_data    = dresp_data_ok ? raw : rnd64();
            #1;
            if (dreq_valid) begin
                if (dcnt == 0) begin
                    strb = dreq_strobe; daddr = dreq_addr; ddata = dreq_data;
                end else if (dreq_strobe !== strb || dreq_addr !== daddr || dreq_data !== ddata
                             || dreq_size !== size) begin
                    stable = 0;
                end
                dcnt++;
            end
            if (resp_valid) begin
                lat = c; rdata = resp_data; mis = resp_misalign;
                if (stall !== 1'b0) stall_ok = 0;
                break;
            end
            if (stall !== 1'b1) stall_ok = 0;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 0;
        idle_inputs();
        repeat (3) @(negedge clk);
        n_total++;
        if ({stall, resp_valid, resp_misalign, dreq_valid, resp_data, dreq_addr, dreq_size,
             dreq_strobe, dreq_data} !== '0)
            $display("FAIL reset_outputs: stall=%b rv=%b dv=%b rdata=%h daddr=%h expected all 0",
                     stall, resp_valid, dreq_valid, resp_data, dreq_addr);
        else n_pass++;
        reset = 1;
    endtask

    task automatic test_load_word();
        int lat, dcnt; logic [63:0] rd, da, dd; logic mis, st, so; logic [7:0] sb;
        run_op(0, 64'h0000_1000_0000_0004, 3'd2, 0, rnd64(), 64'h8000_0001_1234_5678, 0, 0,
               lat, rd, mis, dcnt, sb, da, dd, st, so);
        n_total++;
        if (lat !== 2) $display("FAIL lw_latency: got %0d expected 2", lat); else n_pass++;
        n_total++;
        if (rd !== 64'hFFFF_FFFF_8000_0001) $display("FAIL lw_data: got %h expected ffffffff80000001", rd);
        else n_pass++;
        n_total++;
        if (so !== 1'b1) $display("FAIL lw_stall: stall profile wrong (got ok=%b expected 1)", so);
        else n_pass++;
    endtask

    task automatic test_store_byte();
        int lat, dcnt; logic [63:0] rd, da, dd; logic mis, st, so; logic [7:0] sb;
        run_op(1, 64'h0000_0000_0000_2003, 3'd0, 0, 64'h0000_0000_0000_00AB, rnd64(), 3, 0,
               lat, rd, mis, dcnt, sb, da, dd, st, so);
        n_total++;
        if (sb !== 8'h08) $display("FAIL sb_strobe: got %h expected 08", sb); else n_pass++;
        n_total++;
        if (dd[31:24] !== 8'hAB) $display("FAIL sb_lane: got %h expected ab", dd[31:24]); else n_pass++;
        n_total++;
        if (st !== 1'b1 || dcnt !== 4) $display("FAIL sb_hold: stable=%b cycles=%0d expected 1/4", st, dcnt);
        else n_pass++;
        n_total++;
        if (rd !== 64'd0 || lat !== 5) $display("FAIL sb_resp: data=%h lat=%0d expected 0/5", rd, lat);
        else n_pass++;
    endtask

    task automatic test_misalign();
        int lat, dcnt; logic [63:0] rd, da, dd; logic mis, st, so; logic [7:0] sb;
        run_op(0, 64'h0000_0000_0000_3001, 3'd1, 0, rnd64(), rnd64(), 0, 0,
               lat, rd, mis, dcnt, sb, da, dd, st, so);
        n_total++;
        if (mis !== 1'b1 || lat !== 1) $display("FAIL mis_flag: mis=%b lat=%0d expected 1/1", mis, lat);
        else n_pass++;
        n_total++;
        if (dcnt !== 0) $display("FAIL mis_nobus: dreq_valid cycles=%0d expected 0", dcnt); else n_pass++;
    endtask

    task automatic test_wait_lbu();
        int lat, dcnt; logic [63:0] rd, da, dd; logic mis, st, so; logic [7:0] sb;
        run_op(0, 64'h0000_0000_0000_4007, 3'd0, 1, rnd64(), 64'h9C11_2233_4455_6677, 0, 3,
               lat, rd, mis, dcnt, sb, da, dd, st, so);
        n_total++;
        if (dcnt !== 1) $display("FAIL lbu_wait_valid: dreq_valid cycles=%0d expected 1", dcnt); else n_pass++;
        n_total++;
        if (rd !== 64'h9C || lat !== 5) $display("FAIL lbu_data: data=%h lat=%0d expected 9c/5", rd, lat);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 64'h20; req_size = 3'd2; #1;
        @(negedge clk);
        req_valid = 0; dresp_addr_ok = 1; #1;
        @(negedge clk);
        dresp_addr_ok = 0; #1;
        n_total++;
        if (dreq_valid !== 1'b0 || stall !== 1'b1)
            $display("FAIL wait_state: dreq_valid=%b stall=%b expected 0/1", dreq_valid, stall);
        else n_pass++;
        @(negedge clk);
        reset = 0; #1;
        n_total++;
        if (stall !== 1'b0 || dreq_valid !== 1'b0 || resp_valid !== 1'b0)
            $display("FAIL reset_mid: stall=%b dv=%b rv=%b expected 0/0/0", stall, dreq_valid, resp_valid);
        else n_pass++;
        @(negedge clk);
        dresp_data_ok = 1;
        @(negedge clk);
        reset = 1; dresp_data_ok = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (resp_valid || stall) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL reset_no_resp: busy/resp cycles=%0d expected 0", seen); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [63:0] addr[3], raw[3];
        logic [2:0]  size[3];
        logic        uns[3];
        int k = 0, first_dv = -1, last_resp = -1, gaps_ok = 1;
        logic prev_dv = 0;
        for (int i = 0; i < 3; i++) begin
            size[i] = 3'($urandom_range(0, 3));
            addr[i] = rnd64() & ~64'(nbytes(size[i]) - 1);
            raw[i]  = rnd64();
            uns[i]  = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 40 && k < 3; c++) begin
            @(negedge clk);
            req_valid = 1; req_write = 0; req_addr = addr[k]; req_size = size[k];
            req_unsigned = uns[k]; dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = raw[k];
            #1;
            if (dreq_valid && !prev_dv) begin
                if (first_dv < 0) first_dv = c;
                else if (c != last_resp + 2) gaps_ok = 0;
            end
            prev_dv = dreq_valid;
            if (resp_valid) begin
                n_total++;
                if (resp_data !== m_load(raw[k], addr[k], size[k], uns[k]))
                    $display("FAIL b2b_data%0d: got %h expected %h", k, resp_data,
                             m_load(raw[k], addr[k], size[k], uns[k]));
                else n_pass++;
                last_resp = c;
                k++;
            end
        end
        idle_inputs();
        n_total++;
        if (k !== 3 || first_dv !== 1 || gaps_ok !== 1)
            $display("FAIL b2b_flow: done=%0d first_dv=%0d gaps_ok=%0d expected 3/1/1", k, first_dv, gaps_ok);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat, dcnt, aok, dok, bad = 0;
        logic [63:0] rd, da, dd, addr, wdata, raw;
        logic mis, st, so, wr, uns, e_mis;
        logic [7:0] sb, e_sb;
        logic [2:0] size;
        for (int t = 0; t < 30; t++) begin
            size  = 3'($urandom_range(0, 3));
            addr  = rnd64();
            if ($urandom_range(0, 2) != 0) addr = addr & ~64'(nbytes(size) - 1);
            wr    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            wdata = rnd64(); raw = rnd64();
            aok   = $urandom_range(0, 3); dok = $urandom_range(0, 3);
            run_op(wr, addr, size, uns, wdata, raw, aok, dok, lat, rd, mis, dcnt, sb, da, dd, st, so);
            e_mis = m_misaligned(addr, size);
            e_sb  = (!e_mis && wr) ? m_strobe(addr, size) : 8'h00;
            n_total++;
            if (lat !== (e_mis ? 1 : 2 + aok + dok) || mis !== e_mis || so !== 1'b1) begin
                $display("FAIL rnd%0d_timing: lat=%0d mis=%b stall_ok=%b expected %0d/%b/1",
                         t, lat, mis, so, e_mis ? 1 : 2 + aok + dok, e_mis);
                bad++;
            end else n_pass++;
            n_total++;
            if (rd !== ((e_mis || wr) ? 64'd0 : m_load(raw, addr, size, uns))) begin
                $display("FAIL rnd%0d_data: got %h expected %h", t, rd,
                         (e_mis || wr) ? 64'd0 : m_load(raw, addr, size, uns));
                bad++;
            end else n_pass++;
            n_total++;
            if (dcnt !== (e_mis ? 0 : aok + 1) || sb !== e_sb || st !== 1'b1
                || (!e_mis && da !== addr) || (!e_mis && wr && dd !== (wdata << (8 * int'(addr % 8))))) begin
                $display("FAIL rnd%0d_bus: cycles=%0d strobe=%h addr=%h data=%h stable=%b expected %0d/%h/%h/%h/1",
                         t, dcnt, sb, da, dd, st, e_mis ? 0 : aok + 1, e_sb, addr,
                         wdata << (8 * int'(addr % 8)));
                bad++;
            end else n_pass++;
            if (bad > 10) break;
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_misalign();
        test_wait_lbu();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
